// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing with region FSM decode, registered sync/RGB pins and frame tick
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    output logic        frame_tick,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B
);

    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FP     = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BP     = 2'd3;

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [1:0] h_state, v_state;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic [3:0] r_q, r_d;
    logic [3:0] g_q, g_d;
    logic [3:0] b_q, b_d;

    function automatic logic [1:0] region(input logic [9:0] cnt, input logic [9:0] fp_start,
                                          input logic [9:0] sync_start, input logic [9:0] bp_start);
        if (cnt < fp_start)        return ST_ACTIVE;
        else if (cnt < sync_start) return ST_FP;
        else if (cnt < bp_start)   return ST_SYNC;
        else                       return ST_BP;
    endfunction

    always_comb begin
        h_state = region(h_cnt_q, H_FP_START, H_SYNC_START, H_BP_START);
        v_state = region(v_cnt_q, V_FP_START, V_SYNC_START, V_BP_START);

        h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        active     = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
        x          = active ? {2'b00, h_cnt_q + 10'd1} : 12'd0;
        y          = active ? {2'b00, v_cnt_q + 10'd1} : 12'd0;
        frame_tick = (h_cnt_q == 10'd0) && (v_cnt_q == V_FP_START);

        // Pins are captured from the same counter state as x/y, so all stay aligned one cycle later
        hs_d = (h_state != ST_SYNC);
        vs_d = (v_state != ST_SYNC);
        r_d  = active ? {4{color[2]}} : 4'h0;
        g_d  = active ? {4{color[1]}} : 4'h0;
        b_d  = active ? {4{color[0]}} : 4'h0;
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            r_q     <= 4'h0;
            g_q     <= 4'h0;
            b_q     <= 4'h0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;
    assign VGA_R  = r_q;
    assign VGA_G  = g_q;
    assign VGA_B  = b_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing on a scaled-down raster
module tb_vga_timing;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pins_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        const_mode = 1'b0;
    logic [2:0]  color;
    logic [11:0] x, y;
    logic        active, frame_tick;
    logic        vga_hs, vga_vs;
    logic [3:0]  vga_r, vga_g, vga_b;

    pins_t exp_q[$];
    int mh, mv, cyc;
    int n_checks = 0;
    int n_pass = 0;
    int tick_cnt, first_tick, last_tick, hs_run, vs_run;

    function automatic logic [2:0] img(input int xx, input int yy, input logic cm);
        return cm ? 3'b101 : 3'(xx + yy);
    endfunction

    assign color = img(int'(x), int'(y), const_mode);

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .CLOCK_25  (clk),
        .RESET_N   (rst_n),
        .color     (color),
        .x         (x),
        .y         (y),
        .active    (active),
        .frame_tick(frame_tick),
        .VGA_HS    (vga_hs),
        .VGA_VS    (vga_vs),
        .VGA_R     (vga_r),
        .VGA_G     (vga_g),
        .VGA_B     (vga_b)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", tag, got, exp, mh, mv);
    endtask

    task automatic reset_stats();
        tick_cnt   = 0;
        first_tick = -1;
        last_tick  = 0;
        hs_run     = 0;
        vs_run     = 0;
        cyc        = 0;
        mh         = 0;
        mv         = 0;
        exp_q.delete();
    endtask

    task automatic sample(input bit from_q);
        bit    act;
        pins_t got;
        pins_t e;
        logic [2:0] c;
        act = (mh < HA) && (mv < VA);
        check("active", int'(active), int'(act));
        check("x", int'(x), act ? mh + 1 : 0);
        check("y", int'(y), act ? mv + 1 : 0);
        check("frame_tick", int'(frame_tick), int'(mh == 0 && mv == VA));
        got = {vga_hs, vga_vs, vga_r, vga_g, vga_b};
        if (!from_q) check("pins_reset", int'(got), 14'h3000);
        else if (exp_q.size() == 0) check("pins_queue_empty", 0, 1);
        else check("pins", int'(got), int'(exp_q.pop_front()));

        if (frame_tick) begin
            tick_cnt++;
            if (first_tick < 0) first_tick = cyc;
            else check("tick_period", cyc - last_tick, HT * VT);
            last_tick = cyc;
        end
        if (!vga_hs) hs_run++;
        else begin
            if (hs_run > 0) check("hs_low_width", hs_run, HS);
            hs_run = 0;
        end
        if (!vga_vs) vs_run++;
        else begin
            if (vs_run > 0) check("vs_low_width", vs_run, VS * HT);
            vs_run = 0;
        end

        c    = img(act ? mh + 1 : 0, act ? mv + 1 : 0, const_mode);
        e.hs = !(mh >= HA + HF && mh < HA + HF + HS);
        e.vs = !(mv >= VA + VF && mv < VA + VF + VS);
        e.r  = act ? {4{c[2]}} : 4'h0;
        e.g  = act ? {4{c[1]}} : 4'h0;
        e.b  = act ? {4{c[0]}} : 4'h0;
        exp_q.push_back(e);

        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sample(1'b1);
    endtask

    initial begin
        reset_stats();
        repeat (5) @(posedge clk);
        #1;
        check("rst_x", int'(x), 1);
        check("rst_y", int'(y), 1);
        check("rst_active", int'(active), 1);
        check("rst_tick", int'(frame_tick), 0);
        check("rst_pins", int'({vga_hs, vga_vs, vga_r, vga_g, vga_b}), 14'h3000);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sample(1'b0);
        repeat (2 * HT * VT + 5) step();
        check("tick_count_2frames", tick_cnt, 2);
        check("first_tick_cycle", first_tick, VA * HT);

        @(posedge clk);
        #1;
        const_mode = 1'b1;
        sample(1'b1);
        repeat (HT * VT) step();

        for (int i = 0; i < HT * VT && !(mh == 3 && mv == 2); i++) step();
        check("reach_mid_frame", int'(mh == 3 && mv == 2), 1);
        @(posedge clk);
        #1;
        check("pre_rst_x", int'(x), 4);
        check("pre_rst_y", int'(y), 3);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_x", int'(x), 1);
        check("async_rst_y", int'(y), 1);
        check("async_rst_pins", int'({vga_hs, vga_vs, vga_r, vga_g, vga_b}), 14'h3000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        reset_stats();
        sample(1'b0);
        repeat (HT * VT + 5) step();
        check("tick_count_after_rst", tick_cnt, 1);
        check("first_tick_after_rst", first_tick, VA * HT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

- Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives the pixel coordinates `x` and `y` into `img_generator` and takes back its combinational 3-bit `color`.
- Registers the colour and sync signals into aligned VGA pin outputs.
- Provides a once-per-frame tick that game-logic stages use as their update strobe.

## Interface

Parameters (name, default, meaning):
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch in pixels
- `H_SYNC`, 96, horizontal sync width in pixels
- `H_BP`, 48, horizontal back porch in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch in lines
- `V_SYNC`, 2, vertical sync width in lines
- `V_BP`, 33, vertical back porch in lines

Ports (name, direction, width, meaning):
- `CLOCK_25`, in, 1, pixel clock; the only clock.
- `RESET_N`, in, 1, reset, asynchronous assert, active-low.
- `color`, in, 3, pixel colour from `img_generator` for the current `x`/`y`: bit2 = R, bit1 = G, bit0 = B.
- `x`, out, 12, 1-based column: 1..640 in active region, 0 otherwise.
- `y`, out, 12, 1-based row: 1..480 in active region, 0 otherwise.
- `active`, out, 1, high while the counters are inside the visible region.
- `frame_tick`, out, 1, one-cycle pulse at the first blanking line.
- `VGA_HS`, out, 1, horizontal sync, active-low, registered.
- `VGA_VS`, out, 1, vertical sync, active-low, registered.
- `VGA_R`, out, 4, red DAC value, registered.
- `VGA_G`, out, 4, green DAC value, registered.
- `VGA_B`, out, 4, blue DAC value, registered.

## Operation

Counters:
- `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. It wraps to 0 after 799.
- `v_cnt` counts 0..V_TOTAL-1, where V_TOTAL = 525. It increments only in the cycle where `h_cnt` wraps, and wraps to 0 after 524.
- Counters are 10 bits internally; `x` and `y` are zero-extended to 12 bits.

Horizontal regions, in order (a state machine decoded from `h_cnt`):
- ACTIVE: 0..639
- FP: 640..655
- SYNC: 656..751
- BP: 752..799

Vertical regions follow the same pattern on `v_cnt`:
- ACTIVE: 0..479
- FP: 480..489
- SYNC: 490..491
- BP: 492..524

Combinational outputs (decoded from the counter registers, no extra latency):
- `active` = (`h_cnt` < 640) and (`v_cnt` < 480).
- `x` = `active` ? `h_cnt`+1 : 0.
- `y` = `active` ? `v_cnt`+1 : 0.
- `frame_tick` = (`h_cnt` == 0) and (`v_cnt` == 480).

Output register stage (one flop layer, updated every clock):
- `VGA_HS` <= not (`h_cnt` in 656..751).
- `VGA_VS` <= not (`v_cnt` in 490..491).
- `VGA_R` <= `active` ? {4{color[2]}} : 0.
- `VGA_G` <= `active` ? {4{color[1]}} : 0.
- `VGA_B` <= `active` ? {4{color[0]}} : 0.
- RGB is forced to 0 outside the active region regardless of `color`.

Reset:
- Asserting `RESET_N` low at any time, including mid-line or mid-frame, immediately clears `h_cnt` and `v_cnt` to 0.
- Reset also forces `VGA_HS`=1, `VGA_VS`=1 and `VGA_R`/`VGA_G`/`VGA_B`=0.
- During reset: `active`=1, `x`=1, `y`=1, `frame_tick`=0.
- On the first rising edge after deassertion, counting resumes from (0,0). No partial frame is replayed.

## Timing

- `x`, `y`, `active` and `frame_tick` change on the `CLOCK_25` edge that updates the counters.
- `color` must be valid within the same cycle; `img_generator` is purely combinational from `x`/`y`.
- Pin latency: the colour for counter value (h,v) appears on `VGA_R`/`VGA_G`/`VGA_B` one cycle later. Sync pins carry the same one-cycle delay, so all pins stay mutually aligned.
- Line period: 800 cycles. Frame period: 420,000 cycles.
- `frame_tick` is high exactly 1 cycle per 420,000.
- `VGA_HS` is low for 96 consecutive cycles per line.
- `VGA_VS` is low for 1600 consecutive cycles per frame.
- Simultaneous wrap: at (799,524) the next state is (0,0), and `x`=1, `y`=1 in that same cycle.

## Test plan

- Reset release: hold `RESET_N`=0 for 5 cycles, then release. Pins read `VGA_HS`=1, `VGA_VS`=1, RGB=0 during reset. The first cycle after release shows `x`=1, `y`=1, `active`=1.
- Horizontal timing: run one line.
  - `x` runs 1..640, then 0 for 160 cycles.
  - `VGA_HS` falls 657 cycles after line start (counter 656 plus 1-cycle register) and stays low for 96 cycles.
- Frame timing: run 2 full frames.
  - `frame_tick` pulses exactly twice, 420,000 cycles apart, first at cycle 480×800 = 384,000.
  - `VGA_VS` is low for 1600 cycles starting at line 490 (+1 cycle).
- Colour gating: drive `color`=3'b101 constantly. `VGA_R`=4'hF, `VGA_G`=0, `VGA_B`=4'hF during active pixels, one cycle delayed; all three are 0 during blanking.
- Wrap corner: check the counters step (799,479)->(0,480) and (799,524)->(0,0), with `y` becoming 0 and then 1 at those steps.
- Mid-frame reset: assert `RESET_N`=0 asynchronously at (300,200) between clock edges. Outputs clear immediately, without waiting for a clock edge, and the next frame restarts with a `frame_tick` at cycle 384,000 after release.
